pt_frame_gen: RTL and testbench

Parametrised PT2262-compatible frame encoder, the successor to the per-bit code-bit and sync-bit generators. It accepts a full tri-state address/data word over a valid/ready handshake. It then serialises the word as NBITS code bits followed by one sync bit, with every pulse timed in units of alpha (α). The frame is repeated REPEAT times, or until a stop request. Output q drives the RF/UART-side modulator directly.

---
 rtl/pt_pkg.sv | 42 ++++
 rtl/pt_alpha_tick.sv | 33 +++
 rtl/pt_frame_gen.sv | 149 ++++++++++++++
 tb/tb_pt_frame_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared definitions for the PT2262-compatible frame encoder.
// Contents: trit encodings, pulse widths in units of alpha, FSM state codes, and a helper
// that gives the output level inside one code bit.
package pt_pkg;

    // Trit encodings; 2'b11 is reserved and treated as F.
    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b01;
    localparam logic [1:0] TRIT_F = 2'b10;

    // Pulse widths in alpha units.
    localparam int unsigned SHORT_A = 4;
    localparam int unsigned LONG_A  = 12;
    localparam int unsigned HALF_A  = 16;
    localparam int unsigned BIT_A   = 32;
    localparam int unsigned SYNC_A  = 128;

    // FSM state codes.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BIT  = 2'd1;
    localparam state_t ST_SYNC = 2'd2;

    // Output level at alpha position acnt (0..BIT_A-1) inside a code bit carrying trit.
    function automatic logic bit_level(input logic [1:0] trit, input logic [6:0] acnt);
        logic       second_half;
        logic [6:0] pos;
        logic [6:0] width;
        second_half = (acnt >= 7'(HALF_A));
        pos         = second_half ? (acnt - 7'(HALF_A)) : acnt;
        if (trit == TRIT_0) begin
            width = 7'(SHORT_A);
        end else if (trit == TRIT_1) begin
            width = 7'(LONG_A);
        end else begin
            // F and the reserved code: short pulse first, long pulse second.
            width = second_half ? 7'(LONG_A) : 7'(SHORT_A);
        end
        return pos < width;
    endfunction

endpackage

// File: rtl/pt_alpha_tick.sv
// Alpha prescaler: counts 0..DIV-1 while enabled and strobes tick on the wrap cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the count so the next alpha is a full DIV cycles long
//   en       : count enable
//   tick     : one-cycle strobe marking the last cycle of each alpha
module pt_alpha_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = en && (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pt_frame_gen.sv
// PT2262-compatible frame encoder. Accepts a trit word over valid/ready and sends it as
// NBITS code bits (trit 0 first) followed by a sync bit, REPEAT times or until stop.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   code     : 2*NBITS trit word, trit i at code[2i+1:2i]
//   valid    : code is offered; accepted on a rising edge with ready
//   ready    : high in IDLE
//   stop     : finish the current frame, then return to IDLE
//   q        : registered serial output
//   busy     : high while not IDLE
//   done     : one-cycle pulse on the cycle IDLE is re-entered
module pt_frame_gen
    import pt_pkg::*;
#(
    parameter int unsigned NBITS     = 12,
    parameter int unsigned ALPHA_DIV = 1,
    parameter int unsigned REPEAT    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*NBITS-1:0] code,
    input  logic               valid,
    output logic               ready,
    input  logic               stop,
    output logic               q,
    output logic               busy,
    output logic               done
);

    localparam int unsigned TW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned RW = $clog2(REPEAT) + 1;

    state_t             state_q, state_d;
    logic [6:0]         acnt_q, acnt_d;
    logic [TW-1:0]      tidx_q, tidx_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [2*NBITS-1:0] sreg_q, sreg_d;
    logic               stop_seen_q, stop_seen_d;
    logic               q_q, q_d;
    logic               done_q, done_d;
    logic               accept;
    logic               alpha_tick;

    assign ready  = (state_q == ST_IDLE);
    assign busy   = !ready;
    assign accept = valid && ready;
    assign q      = q_q;
    assign done   = done_q;

    pt_alpha_tick #(
        .DIV (ALPHA_DIV)
    ) u_alpha_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (busy),
        .tick  (alpha_tick)
    );

    always_comb begin
        state_d     = state_q;
        acnt_d      = acnt_q;
        tidx_d      = tidx_q;
        rcnt_d      = rcnt_q;
        sreg_d      = sreg_q;
        stop_seen_d = stop_seen_q;
        done_d      = 1'b0;
        q_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_seen_d = 1'b0;
                if (accept) begin
                    sreg_d  = code;
                    acnt_d  = '0;
                    tidx_d  = '0;
                    rcnt_d  = '0;
                    state_d = ST_BIT;
                end
            end
            ST_BIT: begin
                stop_seen_d = stop_seen_q || stop;
                // q is registered from the current position, so it trails the counters by
                // one cycle; this gives the one-cycle accept-to-q latency.
                q_d = bit_level(sreg_q[1:0], acnt_q);
                if (alpha_tick) begin
                    if (acnt_q == 7'(BIT_A - 1)) begin
                        acnt_d = '0;
                        // Rotate so the latched word is intact again after NBITS trits.
                        sreg_d = (sreg_q >> 2) | (sreg_q << (2 * NBITS - 2));
                        if (tidx_q == TW'(NBITS - 1)) begin
                            tidx_d  = '0;
                            state_d = ST_SYNC;
                        end else begin
                            tidx_d = tidx_q + 1'b1;
                        end
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                stop_seen_d = stop_seen_q || stop;
                q_d         = (acnt_q < 7'(SHORT_A));
                if (alpha_tick) begin
                    if (acnt_q == 7'(SYNC_A - 1)) begin
                        acnt_d = '0;
                        // A stop in this final cycle still counts for this frame.
                        if (stop_seen_q || stop || (rcnt_q == RW'(REPEAT - 1))) begin
                            stop_seen_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            rcnt_d  = rcnt_q + 1'b1;
                            state_d = ST_BIT;
                        end
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acnt_q      <= '0;
            tidx_q      <= '0;
            rcnt_q      <= '0;
            sreg_q      <= '0;
            stop_seen_q <= 1'b0;
            q_q         <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acnt_q      <= acnt_d;
            tidx_q      <= tidx_d;
            rcnt_q      <= rcnt_d;
            sreg_q      <= sreg_d;
            stop_seen_q <= stop_seen_d;
            q_q         <= q_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pt_frame_gen.sv
// Scoreboard bench for pt_frame_gen: stimulus pushes the expected per-cycle
// {q, busy, done, ready} sequence of each accepted word; a negedge monitor pops and compares.
module tb_pt_frame_gen;

    localparam int NB = 3;
    localparam int AD = 2;
    localparam int RP = 3;
    localparam int FC = (NB * 32 + 128) * AD;  // cycles per frame

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid = 1'b0;
    logic            stop = 1'b0;
    logic [2*NB-1:0] code = '0;
    logic            ready, q, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic q;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    obs_t exp_q[$];

    pt_frame_gen #(
        .NBITS     (NB),
        .ALPHA_DIV (AD),
        .REPEAT    (RP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .code  (code),
        .valid (valid),
        .ready (ready),
        .stop  (stop),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference level of q at cycle cyc (0..FC-1) of a frame carrying word w.
    function automatic logic ref_level(input logic [2*NB-1:0] w, input int cyc);
        int         a;
        int         u;
        int         width;
        logic [1:0] t;
        a = cyc / AD;
        if (a < NB * 32) begin
            u = a % 32;
            t = w[2*(a/32) +: 2];
            if (t == 2'b00)      width = 4;
            else if (t == 2'b01) width = 12;
            else                 width = (u < 16) ? 4 : 12;
            return (u % 16) < width;
        end
        return (a - NB * 32) < 4;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got q=%b busy=%b done=%b ready=%b want q=%b busy=%b done=%b ready=%b",
                     name, $time, act.q, act.busy, act.done, act.ready,
                     exp.q, exp.busy, exp.done, exp.ready);
        end
    endtask

    // Cycle 0 is the first busy cycle; cycle n (n = frames*FC) is the done cycle.
    task automatic push_word(input logic [2*NB-1:0] w, input int frames);
        int   n;
        obs_t e;
        n = frames * FC;
        for (int k = 0; k <= n; k++) begin
            e.q     = (k == 0) ? 1'b0 : ref_level(w, (k - 1) % FC);
            e.busy  = (k < n);
            e.done  = (k == n);
            e.ready = (k == n);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        if (!rst) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = obs_t'(4'b0001);
            check("cycle", {q, busy, done, ready}, e);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    // stop_at: busy-cycle index at which stop is pulsed for one cycle (-1 for none).
    task automatic drive_word(input logic [2*NB-1:0] w, input int stop_at,
                              input bit hold, input bit churn);
        int frames;
        int k;
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_before_word t=%0t got ready=%b want 1", $time, ready);
        end
        code  = w;
        valid = 1'b1;
        @(posedge clk);
        #1;
        frames = RP;
        if (stop_at >= 0 && (stop_at / FC + 1) < RP) frames = stop_at / FC + 1;
        push_word(w, frames);
        if (!hold) valid = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (ready) begin
                stop = 1'b0;
                break;
            end
            stop = (k == stop_at);
            if (churn) code = 2*NB'($urandom);
            k++;
            if (k > RP * FC + 10) begin
                checks++;
                errors++;
                $display("FAIL done_timeout t=%0t got ready=%b after %0d cycles want 1",
                         $time, ready, k);
                break;
            end
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {q, busy, done, ready}, obs_t'(4'b0001));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // All-zero word, then mixed trits including the reserved 2'b11.
        drive_word(6'b000000, -1, 1'b0, 1'b0);
        idle(5);
        drive_word(6'b111001, -1, 1'b0, 1'b0);
        idle(3);

        // Stop mid frame 1, and stop on the very last cycle of frame 0.
        drive_word(2*NB'($urandom), FC + FC / 2, 1'b0, 1'b0);
        idle(4);
        drive_word(2*NB'($urandom), FC - 1, 1'b0, 1'b0);
        idle(4);

        // Stop held in IDLE, including the accepting cycle, must be ignored.
        stop = 1'b1;
        idle(3);
        drive_word(2*NB'($urandom), -1, 1'b0, 1'b0);
        idle(2);

        // Back-to-back words with valid held and code churning while busy.
        drive_word(2*NB'($urandom), -1, 1'b1, 1'b1);
        drive_word(2*NB'($urandom), -1, 1'b1, 1'b1);
        drive_word(2*NB'($urandom), -1, 1'b0, 1'b1);
        idle(3);

        // Reset 50 cycles into a frame.
        code  = 2*NB'($urandom);
        valid = 1'b1;
        @(posedge clk);
        #1;
        push_word(code, RP);
        valid = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset", {q, busy, done, ready}, obs_t'(4'b0001));
        repeat (2) @(negedge clk);
        check("held_reset", {q, busy, done, ready}, obs_t'(4'b0001));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        idle(2);
        drive_word(2*NB'($urandom), -1, 1'b0, 1'b0);
        idle(2);

        // Random words with random stop points.
        for (int i = 0; i < 2; i++) begin
            drive_word(2*NB'($urandom), int'($urandom_range(0, RP * FC - 1)), 1'b0, 1'b1);
            idle(int'($urandom_range(0, 4)));
        end

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
